daq_capture_fifo: RTL and testbench

//  Stage directly downstream of the DAQ Wishbone master. Tracks each master transaction via start/write/active.
//  On completion of every read, captures data_rd with a 16-bit sequence tag into a first-word-fall-through FIFO.

---
 rtl/daq_capture_fifo_if.sv | 12 +
 rtl/daq_capture_fifo.sv | 145 ++++++++++++++
 tb/tb_daq_capture_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/daq_capture_fifo_if.sv
// Analysis-side drain stream of the DAQ capture FIFO: head word, sequence tag, valid/ready.
interface daq_capture_fifo_if #(
   parameter int dw = 32
);
   logic          out_valid;
   logic          out_ready;
   logic [dw-1:0] out_data;
   logic [15:0]   out_seq;

   modport master (output out_valid, output out_data, output out_seq, input out_ready);
   modport slave  (input out_valid, input out_data, input out_seq, output out_ready);
endinterface

// File: rtl/daq_capture_fifo.sv
// Tracks Wishbone master transactions and captures read data with a sequence tag
// into a first-word-fall-through FIFO drained over a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start & enable
// WAIT  | start accepted, waiting for active to rise (timeout timer running)
// BUSY  | master busy; capture on active falling if the transaction is a read
module daq_capture_fifo #(
   parameter int dw      = 32,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                     wb_clk,
   input  logic                     wb_rst_n,
   input  logic                     enable,
   input  logic                     clear,
   input  logic                     start,
   input  logic                     write,
   input  logic                     active,
   input  logic [dw-1:0]            data_rd,
   daq_capture_fifo_if.master       out_if,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic                     timeout,
   output logic [15:0]              drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, BUSY} state_t;

   state_t        state, state_nx;
   logic          is_rd, is_rd_nx;
   logic [TW-1:0] timer, timer_nx;
   logic          to_hit;
   logic          push;

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   seq;
   logic [dw+15:0] mem [DEPTH];
   logic          pop, push_ok, drop;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         is_rd <= 1'b0;
         timer <= '0;
      end else if (clear) begin
         state <= IDLE;
         is_rd <= 1'b0;
         timer <= '0;
      end else begin
         state <= state_nx;
         is_rd <= is_rd_nx;
         timer <= timer_nx;
      end
   end

   // Timer counts down from TIMEOUT-1; reaching zero while still waiting is the timeout.
   always_comb begin
      state_nx = state;
      is_rd_nx = is_rd;
      timer_nx = timer;
      to_hit   = 1'b0;
      push     = 1'b0;
      case (state)
         IDLE: begin
            if (start && enable) begin
               is_rd_nx = ~write;
               timer_nx = TLOAD;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (active) begin
               state_nx = BUSY;
            end else if (timer == '0) begin
               to_hit   = 1'b1;
               state_nx = IDLE;
            end else begin
               timer_nx = timer - 1'b1;
            end
         end
         BUSY: begin
            if (!active) begin
               push     = is_rd;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign full             = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign out_if.out_valid = (count != '0);
   assign out_if.out_data  = out_if.out_valid ? mem[rd_ptr][dw-1:0] : '0;
   assign out_if.out_seq   = out_if.out_valid ? mem[rd_ptr][dw+15:dw] : '0;

   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign pop     = out_if.out_valid & out_if.out_ready;
   assign push_ok = push & (~full | pop);
   assign drop    = push & full & ~pop;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         seq        <= '0;
         overflow   <= 1'b0;
         timeout    <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         seq        <= '0;
         overflow   <= 1'b0;
         timeout    <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
            seq    <= seq + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
         end
         if (to_hit) timeout <= 1'b1;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (push_ok && !clear) mem[wr_ptr] <= {seq, data_rd};
   end
endmodule

// File: tb/tb_daq_capture_fifo.sv
// Bench for daq_capture_fifo: directed vector table, corner sequences and a randomized run
// checked every cycle against a queue-based reference model.
module tb_daq_capture_fifo;
   localparam int DEPTH = 16;

   logic        wb_clk = 1'b0;
   logic        wb_rst_n = 1'b0;
   logic        enable = 1'b0, clear = 1'b0, start = 1'b0, write = 1'b0, active = 1'b0;
   logic [31:0] data_rd = '0;
   logic [4:0]  count;
   logic        full, overflow, timeout;
   logic [15:0] drop_count;

   daq_capture_fifo_if #(.dw(32)) sif ();

   daq_capture_fifo #(.dw(32), .DEPTH(DEPTH), .TIMEOUT(255)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable), .clear(clear),
      .start(start), .write(write), .active(active), .data_rd(data_rd),
      .out_if(sif), .count(count), .full(full), .overflow(overflow),
      .timeout(timeout), .drop_count(drop_count)
   );

   always #5 wb_clk = ~wb_clk;

   int checks = 0;
   int errors = 0;
   int rdy_pct = 50;

   logic [47:0] mq[$];
   logic [15:0] mseq = '0, mdrop = '0;
   bit          movf = 0, mto = 0;

   typedef struct {
      bit          wr;
      logic [31:0] data;
      int          exp_count;
      logic [31:0] exp_data;
      logic [15:0] exp_seq;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mseq = '0; mdrop = '0; movf = 0; mto = 0;
   endtask

   // One clock edge: advance the model with the inputs as driven, then compare after the edge.
   task automatic cyc(input bit push_here, input logic [31:0] d);
      bit pop;
      pop = sif.out_ready && (mq.size() != 0);
      if (clear) begin
         model_reset();
      end else if (push_here && mq.size() == DEPTH && !pop) begin
         movf = 1;
         if (mdrop != 16'hFFFF) mdrop++;
      end else begin
         if (pop) void'(mq.pop_front());
         if (push_here) begin
            mq.push_back({mseq, d});
            mseq++;
         end
      end
      @(posedge wb_clk);
      #1;
      check("count", 48'(count), 48'(mq.size()));
      check("out_valid", 48'(sif.out_valid), 48'(mq.size() != 0));
      check("out_data", 48'(sif.out_data), (mq.size() != 0) ? 48'(mq[0][31:0]) : 48'd0);
      check("out_seq", 48'(sif.out_seq), (mq.size() != 0) ? 48'(mq[0][47:32]) : 48'd0);
      check("full", 48'(full), 48'(mq.size() == DEPTH));
      check("overflow", 48'(overflow), 48'(movf));
      check("drop_count", 48'(drop_count), 48'(mdrop));
      check("timeout", 48'(timeout), 48'(mto));
   endtask

   task automatic setready(input bit rnd);
      if (rnd) sif.out_ready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic txn(input bit wr, input logic [31:0] d, input int nbusy, input bit en, input bit rnd);
      enable = en; start = 1'b1; write = wr; active = 1'b0;
      setready(rnd);
      cyc(0, '0);
      start = 1'b0; active = 1'b1;
      for (int i = 0; i < nbusy; i++) begin
         setready(rnd);
         if (rnd) enable = $urandom_range(1);
         cyc(0, '0);
      end
      active = 1'b0; data_rd = d;
      setready(rnd);
      cyc(en && !wr, d);
      data_rd = $urandom;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc(0, '0);
      clear = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 32'h11111111, 0, 32'h0,        16'd0};
      tbl[1] = '{1'b0, 32'hCAFE0001, 1, 32'hCAFE0001, 16'd0};
      tbl[2] = '{1'b1, 32'h22222222, 1, 32'hCAFE0001, 16'd0};
      tbl[3] = '{1'b0, 32'h0000BEEF, 2, 32'hCAFE0001, 16'd0};
      tbl[4] = '{1'b0, 32'hA5A5A5A5, 3, 32'hCAFE0001, 16'd0};

      sif.out_ready = 1'b0;
      repeat (2) @(posedge wb_clk);
      #1;
      check("rst_out_valid", 48'(sif.out_valid), 48'd0);
      check("rst_count", 48'(count), 48'd0);
      check("rst_full", 48'(full), 48'd0);
      check("rst_overflow", 48'(overflow), 48'd0);
      check("rst_drop_count", 48'(drop_count), 48'd0);
      check("rst_timeout", 48'(timeout), 48'd0);
      wb_rst_n = 1'b1;
      model_reset();
      cyc(0, '0);

      // Writes filtered, reads tagged from seq 0, head stays the first read.
      for (int i = 0; i < 5; i++) begin
         txn(tbl[i].wr, tbl[i].data, 3, 1'b1, 1'b0);
         check("tbl_count", 48'(count), 48'(tbl[i].exp_count));
         check("tbl_data", 48'(sif.out_data), 48'(tbl[i].exp_data));
         check("tbl_seq", 48'(sif.out_seq), 48'(tbl[i].exp_seq));
      end
      sif.out_ready = 1'b1;
      repeat (4) cyc(0, '0);
      sif.out_ready = 1'b0;

      // start with enable low is ignored
      txn(1'b0, 32'h0BAD0BAD, 2, 1'b0, 1'b0);
      check("en0_count", 48'(count), 48'd0);

      // reset mid-transaction then a fresh read
      enable = 1'b1; start = 1'b1; write = 1'b0;
      cyc(0, '0);
      start = 1'b0; active = 1'b1;
      cyc(0, '0);
      wb_rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst_count", 48'(count), 48'd0);
      @(posedge wb_clk); #1;
      active = 1'b0; wb_rst_n = 1'b1;
      cyc(0, '0);
      txn(1'b0, 32'h5EED0001, 1, 1'b1, 1'b0);
      check("midrst_seq", 48'(sif.out_seq), 48'd0);
      check("midrst_data", 48'(sif.out_data), 48'h5EED0001);

      // overflow: 18 reads into 16 slots
      pulse_clear();
      for (int i = 0; i < 18; i++) txn(1'b0, 32'(i), 1, 1'b1, 1'b0);
      check("ovf_full", 48'(full), 48'd1);
      check("ovf_count", 48'(count), 48'd16);
      check("ovf_flag", 48'(overflow), 48'd1);
      check("ovf_drops", 48'(drop_count), 48'd2);
      sif.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_data", 48'(sif.out_data), 48'(i));
         check("drain_seq", 48'(sif.out_seq), 48'(i));
         cyc(0, '0);
      end
      sif.out_ready = 1'b0;

      // full FIFO, pop on the capture edge: push accepted
      pulse_clear();
      for (int i = 0; i < 16; i++) txn(1'b0, 32'h100 + 32'(i), 1, 1'b1, 1'b0);
      enable = 1'b1; start = 1'b1; write = 1'b0;
      cyc(0, '0);
      start = 1'b0; active = 1'b1;
      cyc(0, '0);
      active = 1'b0; data_rd = 32'hF00DF00D; sif.out_ready = 1'b1;
      cyc(1, 32'hF00DF00D);
      sif.out_ready = 1'b0;
      check("pp_count", 48'(count), 48'd16);
      check("pp_drops", 48'(drop_count), 48'd0);
      check("pp_overflow", 48'(overflow), 48'd0);
      sif.out_ready = 1'b1;
      repeat (15) cyc(0, '0);
      sif.out_ready = 1'b0;
      check("pp_tail_seq", 48'(sif.out_seq), 48'd16);
      check("pp_tail_data", 48'(sif.out_data), 48'hF00DF00D);
      sif.out_ready = 1'b1;
      cyc(0, '0);
      sif.out_ready = 1'b0;

      // timeout after 255 cycles of active low
      enable = 1'b1; start = 1'b1; write = 1'b0; active = 1'b0;
      cyc(0, '0);
      start = 1'b0;
      repeat (254) cyc(0, '0);
      mto = 1;
      cyc(0, '0);
      check("to_flag", 48'(timeout), 48'd1);
      active = 1'b1;
      cyc(0, '0);
      active = 1'b0;
      cyc(0, '0);
      check("to_idle_nocap", 48'(count), 48'd0);

      // clear with 5 entries, then seq restarts
      for (int i = 0; i < 5; i++) txn(1'b0, 32'hC0 + 32'(i), 2, 1'b1, 1'b0);
      check("clr_pre_count", 48'(count), 48'd5);
      pulse_clear();
      check("clr_count", 48'(count), 48'd0);
      check("clr_timeout", 48'(timeout), 48'd0);
      txn(1'b0, 32'hABCD0000, 1, 1'b1, 1'b0);
      check("clr_seq", 48'(sif.out_seq), 48'd0);

      // randomized run against the model, alternating drain pressure
      pulse_clear();
      for (int n = 0; n < 200; n++) begin
         rdy_pct = (n % 50 < 25) ? 12 : 60;
         txn($urandom_range(3) == 0, $urandom, $urandom_range(1, 4),
             $urandom_range(9) != 0, 1'b1);
         for (int g = $urandom_range(2); g > 0; g--) begin
            setready(1'b1);
            cyc(0, '0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
